mem_arbiter: RTL and testbench

Two-port arbiter sharing the core's single unified memory between the core memory port (port 0: instruction fetch and load/store) and an external loader/debug port (port 1). It accepts one request at a time under round-robin priority, drives a variable-latency single-port memory with a req/ack handshake, and returns a registered response to the granted requester. It sits between the `core` datapath memory interface and the memory macro.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_rr_pick.sv | 20 ++
 rtl/mem_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_NPORTS = 2;
  localparam int unsigned ARB_CNT_W  = 8;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational 2-way round-robin selector; last is the index of the most recent winner.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [ARB_NPORTS-1:0] req,
  input  logic                  last,
  output logic [ARB_NPORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single variable-latency memory.
// Optional wait-for-ack timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W/8-1:0]   be0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [DATA_W/8-1:0]   be1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rerr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  localparam int unsigned BE_W = DATA_W / 8;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be in 1..255");
  end

  arb_state_t              r_state, w_state_nxt;
  logic                    r_last_gnt, w_last_gnt_nxt;
  logic                    r_owner, w_owner_nxt;
  logic                    r_mem_req, w_mem_req_nxt;
  logic                    r_we, w_we_nxt;
  logic [ADDR_W-1:0]       r_addr, w_addr_nxt;
  logic [DATA_W-1:0]       r_wdata, w_wdata_nxt;
  logic [BE_W-1:0]         r_be, w_be_nxt;
  logic [DATA_W-1:0]       r_rdata, w_rdata_nxt;
  logic [ARB_NPORTS-1:0]   r_rvalid, w_rvalid_nxt;
  logic [ARB_NPORTS-1:0]   w_pick;
  logic [ARB_NPORTS-1:0]   w_gnt;
`ifdef MEM_ARB_TIMEOUT_EN
  logic                    r_rerr, w_rerr_nxt;
  logic [ARB_CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic                    w_timeout;
`endif

  arb_rr_pick u_pick (
    .req  ({req1, req0}),
    .last (r_last_gnt),
    .gnt  (w_pick)
  );

  // Next-state and next-register values; grants are only issued from IDLE.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    w_owner_nxt    = r_owner;
    w_mem_req_nxt  = r_mem_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_be_nxt       = r_be;
    w_rdata_nxt    = r_rdata;
    w_rvalid_nxt   = '0;
    w_gnt          = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    w_rerr_nxt     = r_rerr;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout      = (r_wait_cnt == ARB_CNT_W'(TIMEOUT - 1));
`endif

    case (r_state)
      IDLE: begin
        w_gnt = w_pick;
        if (|w_pick) begin
          w_owner_nxt    = w_pick[1];
          w_last_gnt_nxt = w_pick[1];
          w_we_nxt       = w_pick[1] ? we1    : we0;
          w_addr_nxt     = w_pick[1] ? addr1  : addr0;
          w_wdata_nxt    = w_pick[1] ? wdata1 : wdata0;
          w_be_nxt       = w_pick[1] ? be1    : be0;
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          w_wait_cnt_nxt = '0;
`endif
        end
      end

      ACCESS: begin
        // A late ack wins over a simultaneous timeout.
        if (mem_ack) begin
          w_rdata_nxt           = r_we ? '0 : mem_rdata;
          w_mem_req_nxt         = 1'b0;
          w_rvalid_nxt[r_owner] = 1'b1;
          w_state_nxt           = RESP;
`ifdef MEM_ARB_TIMEOUT_EN
          w_rerr_nxt            = 1'b0;
        end else if (w_timeout) begin
          w_rdata_nxt           = DATA_W'(ARB_ERR_DATA);
          w_rerr_nxt            = 1'b1;
          w_mem_req_nxt         = 1'b0;
          w_rvalid_nxt[r_owner] = 1'b1;
          w_state_nxt           = RESP;
        end else begin
          w_wait_cnt_nxt        = ARB_CNT_W'(r_wait_cnt + 1'b1);
`endif
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_owner    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
      r_rvalid   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_be       <= w_be_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rvalid   <= w_rvalid_nxt;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rerr     <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_rerr     <= w_rerr_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  assign rerr = r_rerr;
`else
  assign rerr = 1'b0;
`endif

  assign gnt0      = w_gnt[0];
  assign gnt1      = w_gnt[1];
  assign rvalid0   = r_rvalid[0];
  assign rvalid1   = r_rvalid[1];
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus reset, stray-ack and timeout sequences.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [BW-1:0] be0 = '0, be1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, rerr;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rerr(rerr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic          r0, r1, we0, we1;
    logic [31:0]   a0, a1, d0, d1;
    logic [3:0]    b0, b1;
    int unsigned   waits;
    logic [31:0]   mrd;
    logic          stray;
    logic          own;
    logic [31:0]   exp_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // One full transaction: grant cycle, ACCESS cycles with optional waits, RESP cycle.
  task automatic run_txn(input vec_t v);
    logic          e_we;
    logic [31:0]   e_a, e_d;
    logic [3:0]    e_b;
    e_we = v.own ? v.we1 : v.we0;
    e_a  = v.own ? v.a1  : v.a0;
    e_d  = v.own ? v.d1  : v.d0;
    e_b  = v.own ? v.b1  : v.b0;

    @(negedge clk);
    req0 = v.r0; we0 = v.we0; addr0 = v.a0; wdata0 = v.d0; be0 = v.b0;
    req1 = v.r1; we1 = v.we1; addr1 = v.a1; wdata1 = v.d1; be1 = v.b1;
    mem_ack = 1'b0;
    #1;
    chk("grant_gnt0", gnt0, v.own == 1'b0);
    chk("grant_gnt1", gnt1, v.own == 1'b1);
    chk("idle_rvalid0", rvalid0, 0);
    chk("idle_rvalid1", rvalid1, 0);
    chk("idle_mem_req", mem_req, 0);

    for (int w = 0; w <= int'(v.waits); w++) begin
      @(negedge clk);
      if (w == 0) begin
        if (!v.own) begin
          req0 = 1'b0; we0 = ~we0; addr0 = ~addr0; wdata0 = ~wdata0; be0 = ~be0;
        end else begin
          req1 = 1'b0; we1 = ~we1; addr1 = ~addr1; wdata1 = ~wdata1; be1 = ~be1;
        end
      end
      mem_ack   = (w == int'(v.waits));
      mem_rdata = (w == int'(v.waits)) ? v.mrd : (32'hBAD0_0000 | 32'(w));
      #1;
      chk("acc_mem_req", mem_req, 1);
      chk("acc_mem_we", mem_we, e_we);
      chk("acc_mem_addr", mem_addr, e_a);
      chk("acc_mem_wdata", mem_wdata, e_d);
      chk("acc_mem_be", mem_be, e_b);
      chk("acc_gnt", {gnt1, gnt0}, 0);
      chk("acc_rvalid", {rvalid1, rvalid0}, 0);
    end

    @(negedge clk);
    mem_ack   = v.stray;
    mem_rdata = 32'h5555_AAAA;
    #1;
    chk("resp_rvalid0", rvalid0, v.own == 1'b0);
    chk("resp_rvalid1", rvalid1, v.own == 1'b1);
    chk("resp_rdata", rdata, v.exp_rd);
    chk("resp_rerr", rerr, 0);
    chk("resp_mem_req", mem_req, 0);
    chk("resp_gnt", {gnt1, gnt0}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // r0 r1 we0 we1 a0 a1 d0 d1 b0 b1 waits mrd stray own exp_rd
    tbl[0] = '{1, 0, 0, 0, 32'h100, 32'h0,   32'h0,         32'h0,         4'hF, 4'h0, 0, 32'h1234_5678, 0, 0, 32'h1234_5678};
    tbl[1] = '{1, 1, 0, 0, 32'h200, 32'h300, 32'h0,         32'h0,         4'hF, 4'hF, 0, 32'hA5A5_0001, 0, 1, 32'hA5A5_0001};
    tbl[2] = '{1, 1, 0, 0, 32'h204, 32'h304, 32'h0,         32'h0,         4'hF, 4'hF, 0, 32'hA5A5_0002, 1, 0, 32'hA5A5_0002};
    tbl[3] = '{1, 1, 0, 0, 32'h208, 32'h308, 32'h0,         32'h0,         4'hF, 4'hF, 1, 32'hA5A5_0003, 0, 1, 32'hA5A5_0003};
    tbl[4] = '{1, 1, 0, 0, 32'h20C, 32'h30C, 32'h0,         32'h0,         4'hF, 4'hF, 0, 32'hA5A5_0004, 0, 0, 32'hA5A5_0004};
    tbl[5] = '{0, 1, 0, 1, 32'h0,   32'h20,  32'h0,         32'hCAFE_F00D, 4'h0, 4'h3, 3, 32'h7777_7777, 0, 1, 32'h0};
    tbl[6] = '{1, 1, 1, 0, 32'h40,  32'h44,  32'h1122_3344, 32'h0,         4'hC, 4'hF, 2, 32'h9999_9999, 1, 0, 32'h0};
    tbl[7] = '{0, 1, 0, 0, 32'h0,   32'h80,  32'h0,         32'h0,         4'h0, 4'hF, 0, 32'h0F0F_0F0F, 0, 1, 32'h0F0F_0F0F};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rerr", rerr, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    reset = 1'b1;

    // Stray ack in IDLE
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_idle_mem_req", mem_req, 0);
    chk("stray_idle_rvalid", {rvalid1, rvalid0}, 0);
    chk("stray_idle_rdata", rdata, 0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    chk("post_tbl_rvalid", {rvalid1, rvalid0}, 0);

    // Reset in the middle of ACCESS
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h400; be0 = 4'hF;
    #1;
    chk("mid_rst_gnt0", gnt0, 1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    chk("mid_rst_pre_mem_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_no_rvalid", {rvalid1, rvalid0}, 0);
      chk("mid_rst_idle_mem_req", mem_req, 0);
    end
    run_txn('{1, 1, 0, 0, 32'h600, 32'h700, 32'h0, 32'h0, 4'hF, 4'hF, 0, 32'h3C3C_3C3C, 0, 0, 32'h3C3C_3C3C});

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: four ACCESS cycles, then error response
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; addr0 = 32'h500; mem_ack = 1'b0;
    #1;
    chk("to_gnt0", gnt0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0 = 1'b0;
      #1;
      chk("to_mem_req", mem_req, 1);
      chk("to_rvalid", {rvalid1, rvalid0}, 0);
    end
    @(negedge clk);
    #1;
    chk("to_drop_mem_req", mem_req, 0);
    chk("to_rvalid0", rvalid0, 1);
    chk("to_rerr", rerr, 1);
    chk("to_rdata", rdata, 32'hDEAD_BEEF);

    // Ack on the fourth cycle wins over the timeout
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h504;
    #1;
    chk("to_ack_gnt0", gnt0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0 = 1'b0;
      mem_ack = (k == 3);
      mem_rdata = 32'h0BAD_C0DE;
      #1;
      chk("to_ack_mem_req", mem_req, 1);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("to_ack_rvalid0", rvalid0, 1);
    chk("to_ack_rerr", rerr, 0);
    chk("to_ack_rdata", rdata, 32'h0BAD_C0DE);
`endif

    @(negedge clk);
    #1;
    chk("final_rvalid", {rvalid1, rvalid0}, 0);
    chk("final_mem_req", mem_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
